// File: rtl/coin_collector.sv
// Coin-operated front end feeding the cash handler: credit, select, vend, refund.
// Optional idle auto-refund is built when TIMEOUT_EN is defined.
module coin_collector #(
  parameter int W           = 11,
  parameter int PRICE0      = 3,
  parameter int PRICE1      = 5,
  parameter int PRICE2      = 7,
  parameter int PRICE3      = 10,
  parameter int CREDIT_MAX  = 2047,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         coin_valid,
  input  logic [1:0]   coin_type,
  input  logic         sel_valid,
  input  logic [1:0]   sel_item,
  input  logic         cancel,
  output logic         ch_mode,
  output logic         ch_func,
  output logic [W-1:0] ch_amount,
  output logic         ch_req,
  input  logic         ch_res,
  output logic [W-1:0] credit,
  output logic         busy,
  output logic         coin_reject,
  output logic         sel_denied,
  output logic         vend_valid,
  output logic [1:0]   vend_item,
  output logic         refund_valid,
  output logic [W-1:0] refund_amount
);

  if (CREDIT_MAX > (2**W) - 1 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("coin_collector: bad CREDIT_MAX or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_credit;
  logic [W-1:0]   r_price;
  logic [W-1:0]   r_amount;
  logic [W-1:0]   r_refund_amt;
  logic [1:0]     r_item;
  logic [1:0]     r_vend_item;
  logic           r_req;
  logic           r_busy;
  logic           r_coin_rej;
  logic           r_sel_den;
  logic           r_vend;
  logic           r_refund;

  logic [W-1:0]   w_coin_val;
  logic [W-1:0]   w_sel_price;
  logic [W-1:0]   w_credit_add;
  logic [W:0]     w_sum;
  logic           w_idle;
  logic           w_coin_ok;

  always_comb begin
    w_coin_val = '0;
    unique case (coin_type)
      2'd0: w_coin_val = W'(1);
      2'd1: w_coin_val = W'(2);
      2'd2: w_coin_val = W'(5);
      2'd3: w_coin_val = W'(10);
    endcase
  end

  always_comb begin
    w_sel_price = '0;
    unique case (sel_item)
      2'd0: w_sel_price = W'(PRICE0);
      2'd1: w_sel_price = W'(PRICE1);
      2'd2: w_sel_price = W'(PRICE2);
      2'd3: w_sel_price = W'(PRICE3);
    endcase
  end

  // One extra bit so the ceiling check sees a true sum.
  assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_idle       = (r_state == S_IDLE);
  assign w_coin_ok    = coin_valid && w_idle &&
                        (w_sum <= (W+1)'(CREDIT_MAX));
  assign w_credit_add = w_coin_ok ? w_sum[W-1:0] : r_credit;

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_idle_cnt;
  logic          w_strobe;
  logic          w_to_hit;
  assign w_strobe = coin_valid | sel_valid | cancel;
  assign w_to_hit = w_idle && !w_strobe && (r_credit != '0) &&
                    (r_idle_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
    end else if (!w_idle || w_strobe || r_credit == '0 || w_to_hit) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_price      <= '0;
      r_amount     <= '0;
      r_refund_amt <= '0;
      r_item       <= '0;
      r_vend_item  <= '0;
      r_req        <= 1'b0;
      r_busy       <= 1'b0;
      r_coin_rej   <= 1'b0;
      r_sel_den    <= 1'b0;
      r_vend       <= 1'b0;
      r_refund     <= 1'b0;
    end else begin
      r_coin_rej   <= coin_valid && !w_coin_ok;
      r_sel_den    <= 1'b0;
      r_vend       <= 1'b0;
      r_vend_item  <= '0;
      r_refund     <= 1'b0;
      r_refund_amt <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (cancel) begin
            r_credit <= '0;
            if (w_credit_add != '0) begin
              r_refund     <= 1'b1;
              r_refund_amt <= w_credit_add;
            end
          end else begin
            r_credit <= w_credit_add;
            // Affordability uses the credit before this cycle's coin.
            if (sel_valid) begin
              if (r_credit >= w_sel_price) begin
                r_item   <= sel_item;
                r_price  <= w_sel_price;
                r_amount <= w_sel_price;
                r_req    <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= S_REQ;
              end else begin
                r_sel_den <= 1'b1;
              end
            end
`ifdef TIMEOUT_EN
            else if (w_to_hit) begin
              r_credit     <= '0;
              r_refund     <= 1'b1;
              r_refund_amt <= r_credit;
            end
`endif
          end
        end
        S_REQ: begin
          r_req    <= 1'b0;
          r_amount <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ch_res) begin
            r_credit    <= r_credit - r_price;
            r_vend      <= 1'b1;
            r_vend_item <= r_item;
          end else begin
            r_sel_den <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_mode       = 1'b0;
  assign ch_func       = 1'b0;
  assign ch_amount     = r_amount;
  assign ch_req        = r_req;
  assign credit        = r_credit;
  assign busy          = r_busy;
  assign coin_reject   = r_coin_rej;
  assign sel_denied    = r_sel_den;
  assign vend_valid    = r_vend;
  assign vend_item     = r_vend_item;
  assign refund_valid  = r_refund;
  assign refund_amount = r_refund_amt;

endmodule

// File: tb/tb_coin_collector.sv
// Bench for coin_collector: directed scenarios then random traffic
// against a cycle-level reference model of credit and transactions.
module tb_coin_collector;

  localparam int W = 11;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         coin_valid;
  logic [1:0]   coin_type;
  logic         sel_valid;
  logic [1:0]   sel_item;
  logic         cancel;
  logic         ch_mode;
  logic         ch_func;
  logic [W-1:0] ch_amount;
  logic         ch_req;
  logic         ch_res;
  logic [W-1:0] credit;
  logic         busy;
  logic         coin_reject;
  logic         sel_denied;
  logic         vend_valid;
  logic [1:0]   vend_item;
  logic         refund_valid;
  logic [W-1:0] refund_amount;

  always #5 clock = ~clock;

  coin_collector dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .ch_mode      (ch_mode),
    .ch_func      (ch_func),
    .ch_amount    (ch_amount),
    .ch_req       (ch_req),
    .ch_res       (ch_res),
    .credit       (credit),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .sel_denied   (sel_denied),
    .vend_valid   (vend_valid),
    .vend_item    (vend_item),
    .refund_valid (refund_valid),
    .refund_amount(refund_amount)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int coin_tab[4]  = '{1, 2, 5, 10};
  int price_tab[4] = '{3, 5, 7, 10};

  // Model: credit as a plain integer, plus how far into a purchase we are.
  int m_credit, m_phase, m_item, m_price;
  int e_credit, e_busy, e_req, e_amount;
  int e_rej, e_den, e_vend, e_vitem, e_ref, e_ramt;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_phase = 0; m_item = 0; m_price = 0;
    e_credit = 0; e_busy = 0; e_req = 0; e_amount = 0;
    e_rej = 0; e_den = 0; e_vend = 0; e_vitem = 0; e_ref = 0; e_ramt = 0;
  endtask

  task automatic model_step(input logic cv, input logic [1:0] ct,
                            input logic sv, input logic [1:0] si,
                            input logic cn, input logic res);
    int val, nc;
    e_rej = 0; e_den = 0; e_vend = 0; e_vitem = 0; e_ref = 0; e_ramt = 0;
    val = coin_tab[ct];
    if (m_phase == 0) begin
      nc = m_credit;
      if (cv) begin
        if (m_credit + val <= 2047) nc = m_credit + val;
        else e_rej = 1;
      end
      if (cn) begin
        if (nc > 0) begin e_ref = 1; e_ramt = nc; end
        m_credit = 0;
      end else begin
        if (sv) begin
          if (m_credit >= price_tab[si]) begin
            m_phase = 1; m_item = int'(si); m_price = price_tab[si];
          end else e_den = 1;
        end
        m_credit = nc;
      end
    end else if (m_phase == 1) begin
      e_rej = int'(cv);
      m_phase = 2;
    end else begin
      e_rej = int'(cv);
      if (res) begin
        m_credit = m_credit - m_price;
        e_vend = 1; e_vitem = m_item;
      end else e_den = 1;
      m_phase = 0;
    end
    e_credit = m_credit;
    e_busy   = (m_phase != 0) ? 1 : 0;
    e_req    = (m_phase == 1) ? 1 : 0;
    e_amount = (m_phase == 1) ? m_price : 0;
  endtask

  task automatic check_all();
    chk("credit",   int'(credit),        e_credit);
    chk("busy",     int'(busy),          e_busy);
    chk("ch_req",   int'(ch_req),        e_req);
    chk("ch_amt",   int'(ch_amount),     e_amount);
    chk("ch_mode",  int'(ch_mode),       0);
    chk("ch_func",  int'(ch_func),       0);
    chk("coin_rej", int'(coin_reject),   e_rej);
    chk("sel_den",  int'(sel_denied),    e_den);
    chk("vend",     int'(vend_valid),    e_vend);
    chk("vitem",    int'(vend_item),     e_vitem);
    chk("refund",   int'(refund_valid),  e_ref);
    chk("ref_amt",  int'(refund_amount), e_ramt);
  endtask

  task automatic step(input logic cv, input logic [1:0] ct,
                      input logic sv, input logic [1:0] si,
                      input logic cn, input logic res);
    coin_valid = cv; coin_type = ct;
    sel_valid  = sv; sel_item  = si;
    cancel     = cn; ch_res    = res;
    model_step(cv, ct, sv, si, cn, res);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    coin_valid = 1'b0; coin_type = 2'd0;
    sel_valid = 1'b0; sel_item = 2'd0;
    cancel = 1'b0; ch_res = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;
    idle();

    // T2: 5+2, buy item 0, success
    step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t2_credit7", int'(credit), 7);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("t2_req", int'(ch_req), 1);
    chk("t2_amt", int'(ch_amount), 3);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("t2_vend", int'(vend_valid), 1);
    chk("t2_credit4", int'(credit), 4);

    // T3: too expensive
    step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("t3_denied", int'(sel_denied), 1);
    chk("t3_noreq", int'(ch_req), 0);
    chk("t3_credit", int'(credit), 4);

    // T4: handler refuses, then cancel refunds
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t4_denied", int'(sel_denied), 1);
    chk("t4_credit", int'(credit), 7);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("t4_refund", int'(refund_amount), 7);
    chk("t4_zero", int'(credit), 0);

    // T5: ceiling, then coin while busy
    for (int i = 0; i < 204; i++) step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_credit", int'(credit), 2040);
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_reject", int'(coin_reject), 1);
    chk("t5_hold", int'(credit), 2040);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_busyrej", int'(coin_reject), 1);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("t5_after", int'(credit), 2037);

    // T1: reset during WAIT abandons the purchase
    step(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    idle();
    ch_res = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    chk("t1_novend", int'(vend_valid), 0);
    reset_n = 1'b1;
    ch_res = 1'b0;
    idle();

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 40, 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 20, 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 4,  $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
